// File: rtl/segment_pattern_decoder.sv
// Receive-side decoder for a multiplexed active-low 7-segment bus: filters each
// digit's pattern for stability, decodes it to BCD, and reports digit changes as events.
module segment_pattern_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned IDX_W         = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              segment,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [IDX_W-1:0]        ev_index,
    output logic [3:0]              ev_value,
    output logic                    ev_overrun,
    input  logic                    ev_overrun_clr,
    output logic                    pattern_err,
    output logic [7:0]              err_count
);

    localparam int unsigned       CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ACC = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]              s_seg_q, h_seg_q;
    logic [NUM_DIGITS-1:0]   s_en_q, h_en_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dvalid_q, dvalid_d;
    logic                    ev_valid_q, ev_valid_d;
    logic [IDX_W-1:0]        ev_index_q, ev_index_d;
    logic [3:0]              ev_value_q, ev_value_d;
    logic                    ovr_q, ovr_d;
    logic                    perr_q, perr_d;
    logic [7:0]              errc_q, errc_d;

    logic                    same, onehot, accept, change;
    logic [4:0]              dec;
    logic [IDX_W-1:0]        idx;

    // Returns {invalid, value}; blank decodes to value F.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: return 5'h00;
            7'b1001111: return 5'h01;
            7'b0010010: return 5'h02;
            7'b0000110: return 5'h03;
            7'b1001100: return 5'h04;
            7'b0100100: return 5'h05;
            7'b0100000: return 5'h06;
            7'b0001111: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0000100: return 5'h09;
            7'b1111111: return 5'h0F;
            default:    return 5'h10;
        endcase
    endfunction

    always_comb begin
        same   = ({s_seg_q, s_en_q} == {h_seg_q, h_en_q});
        onehot = (s_en_q != '0) && ((s_en_q & (s_en_q - NUM_DIGITS'(1))) == '0);
        accept = same && onehot && (cnt_q == CNT_ACC);
        dec    = decode(s_seg_q);

        cnt_d = cnt_q;
        if (!onehot)
            cnt_d = '0;
        else if (!same)
            cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);

        digits_d = digits_q;
        dvalid_d = dvalid_q;
        change   = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (s_en_q[i]) idx = IDX_W'(i);
            if (accept && s_en_q[i] && !dec[4]) begin
                digits_d[4*i +: 4] = dec[3:0];
                dvalid_d[i]        = (dec[3:0] != 4'hF);
                change             = (digits_q[4*i +: 4] != dec[3:0]);
            end
        end

        perr_d = accept && dec[4];
        errc_d = errc_q;
        if (perr_d && errc_q != 8'hFF)
            errc_d = errc_q + 8'd1;

        // Single holding register: a transfer on the same edge frees the slot for the new event.
        ev_valid_d = ev_valid_q;
        ev_index_d = ev_index_q;
        ev_value_d = ev_value_q;
        ovr_d      = ovr_q;
        if (ev_overrun_clr)
            ovr_d = 1'b0;
        if (change) begin
            if (!ev_valid_q || ev_ready) begin
                ev_valid_d = 1'b1;
                ev_index_d = idx;
                ev_value_d = dec[3:0];
            end else begin
                ovr_d = 1'b1;
            end
        end else if (ev_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_seg_q    <= '0;
            s_en_q     <= '0;
            h_seg_q    <= '0;
            h_en_q     <= '0;
            cnt_q      <= '0;
            digits_q   <= '1;
            dvalid_q   <= '0;
            ev_valid_q <= 1'b0;
            ev_index_q <= '0;
            ev_value_q <= '0;
            ovr_q      <= 1'b0;
            perr_q     <= 1'b0;
            errc_q     <= '0;
        end else begin
            s_seg_q <= segment;
            s_en_q  <= digit_en;
            if (!same) begin
                h_seg_q <= s_seg_q;
                h_en_q  <= s_en_q;
            end
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
            dvalid_q   <= dvalid_d;
            ev_valid_q <= ev_valid_d;
            ev_index_q <= ev_index_d;
            ev_value_q <= ev_value_d;
            ovr_q      <= ovr_d;
            perr_q     <= perr_d;
            errc_q     <= errc_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = dvalid_q;
    assign ev_valid    = ev_valid_q;
    assign ev_index    = ev_index_q;
    assign ev_value    = ev_value_q;
    assign ev_overrun  = ovr_q;
    assign pattern_err = perr_q;
    assign err_count   = errc_q;

endmodule

// File: tb/tb_segment_pattern_decoder.sv
// Bench for segment_pattern_decoder: run-length based reference model checked every
// cycle, plus hand-computed literal expectations along a directed scenario.
module tb_segment_pattern_decoder;

    localparam int ND = 4;
    localparam int S  = 4;
    // Pattern for numeral v lives at PATS[7*v +: 7].
    localparam logic [69:0] PATS = {7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000,
                                    7'b0100100, 7'b1001100, 7'b0000110, 7'b0010010,
                                    7'b1001111, 7'b0000001};

    logic          clk, rst;
    logic [6:0]    segment;
    logic [ND-1:0] digit_en;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_valid;
    logic          ev_valid, ev_ready, ev_overrun, ev_overrun_clr, pattern_err;
    logic [1:0]    ev_index;
    logic [3:0]    ev_value;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;

    segment_pattern_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .segment(segment), .digit_en(digit_en),
        .digits(digits), .digit_valid(digit_valid), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_index(ev_index), .ev_value(ev_value),
        .ev_overrun(ev_overrun), .ev_overrun_clr(ev_overrun_clr),
        .pattern_err(pattern_err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0]    m_lseg;
    logic [ND-1:0] m_len;
    int            m_run;
    logic [3:0]    m_dig [ND];
    logic [ND-1:0] m_dv;
    logic          m_evv, m_ovr, m_perr;
    logic [1:0]    m_idx;
    logic [3:0]    m_val;
    int            m_errc;

    function automatic int dec_val(input logic [6:0] p);
        if (p == 7'h7F) return 15;
        for (int v = 0; v < 10; v++)
            if (PATS[7*v +: 7] == p) return v;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [ND-1:0] e);
        int c = 0;
        int k = -1;
        for (int i = 0; i < ND; i++)
            if (e[i]) begin c++; k = i; end
        return (c == 1) ? k : -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lseg <= '0; m_len <= '0; m_run <= 0;
            for (int i = 0; i < ND; i++) m_dig[i] <= 4'hF;
            m_dv <= '0; m_evv <= 1'b0; m_idx <= '0; m_val <= '0;
            m_ovr <= 1'b0; m_perr <= 1'b0; m_errc <= 0;
        end else begin : mdl
            int  k;
            int  v;
            logic chg;
            k   = onehot_idx(m_len);
            v   = dec_val(m_lseg);
            chg = 1'b0;
            m_perr <= 1'b0;
            // A run of exactly S identical one-hot samples is accepted one edge later.
            if (m_run == S && k >= 0) begin
                if (v < 0) begin
                    m_perr <= 1'b1;
                    if (m_errc != 255) m_errc <= m_errc + 1;
                end else begin
                    chg = (m_dig[k] != 4'(v));
                    m_dig[k] <= 4'(v);
                    m_dv[k]  <= (v != 15);
                end
            end
            if (ev_overrun_clr) m_ovr <= 1'b0;
            if (chg) begin
                if (!m_evv || ev_ready) begin
                    m_evv <= 1'b1; m_idx <= 2'(k); m_val <= 4'(v);
                end else begin
                    m_ovr <= 1'b1;
                end
            end else if (ev_ready) begin
                m_evv <= 1'b0;
            end
            if (m_run > 0 && segment == m_lseg && digit_en == m_len) begin
                if (m_run <= S) m_run <= m_run + 1;
            end else begin
                m_lseg <= segment; m_len <= digit_en; m_run <= 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [4*ND-1:0] ed;
        logic [36:0] act, exp;
        for (int i = 0; i < ND; i++) ed[4*i +: 4] = m_dig[i];
        act = {digits, digit_valid, ev_valid, ev_index, ev_value, ev_overrun, pattern_err, err_count};
        exp = {ed, m_dv, m_evv, m_idx, m_val, m_ovr, m_perr, 8'(m_errc)};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_cmp: got %h expected %h at %0t", act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic [6:0] seg, input logic [ND-1:0] en, input int n);
        segment  = seg;
        digit_en = en;
        repeat (n) cyc();
    endtask

    task automatic pop();
        ev_ready = 1'b1;
        cyc();
        ev_ready = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_digits", 32'(digits), 32'hFFFF);
        chk("rst_dvalid", 32'(digit_valid), 0);
        chk("rst_ev", {29'd0, ev_valid, ev_overrun, pattern_err}, 0);
        chk("rst_idx_val", {26'd0, ev_index, ev_value}, 0);
        chk("rst_errc", 32'(err_count), 0);
    endtask

    initial begin
        rst = 1'b0; segment = 7'h7F; digit_en = '0;
        ev_ready = 1'b0; ev_overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_reset_vals();
        rst = 1'b1;

        // Digit 0 shows "2": five edges to the event, then one transfer.
        hold(7'b0010010, 4'b0001, 4);
        chk("lat_no_ev_yet", 32'(ev_valid), 0);
        cyc();
        chk("d0_val", 32'(digits[3:0]), 2);
        chk("d0_dvalid", 32'(digit_valid[0]), 1);
        chk("ev_0_2", {28'd0, ev_valid, ev_index[0], ev_value[1:0]}, 32'b1010);
        pop();
        chk("ev_drained", 32'(ev_valid), 0);

        // Glitch: a 2-cycle "3" is ignored, the following "8" is reported.
        hold(7'b0000110, 4'b0010, 2);
        hold(7'b0000000, 4'b0010, 4);
        chk("glitch_no_ev", 32'(ev_valid), 0);
        cyc();
        chk("glitch_ev", {25'd0, ev_valid, ev_index, ev_value}, {25'd0, 1'b1, 2'd1, 4'd8});
        pop();

        // Undecodable pattern on digit 2.
        hold(7'b1010101, 4'b0100, 5);
        chk("perr_pulse", 32'(pattern_err), 1);
        chk("errc_1", 32'(err_count), 1);
        chk("d2_unchanged", 32'(digits[11:8]), 32'hF);
        chk("perr_no_ev", 32'(ev_valid), 0);
        cyc();
        chk("perr_one_cycle", 32'(pattern_err), 0);
        for (int r = 0; r < 300; r++)
            hold(7'b1010101, r[0] ? 4'b0100 : 4'b1000, 4);
        hold(7'h7F, 4'b0000, 3);
        chk("errc_sat", 32'(err_count), 255);

        // Overrun: second event dropped while the first is held.
        hold(7'b0100100, 4'b0001, 5);
        hold(7'b0001111, 4'b0010, 5);
        hold(7'h7F, 4'b0000, 1);
        chk("ovr_held_ev", {25'd0, ev_valid, ev_index, ev_value}, {25'd0, 1'b1, 2'd0, 4'd5});
        chk("ovr_set", 32'(ev_overrun), 1);
        chk("ovr_d1_updated", 32'(digits[7:4]), 7);
        ev_overrun_clr = 1'b1;
        cyc();
        ev_overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(ev_overrun), 0);
        pop();

        // Non one-hot enable is never accepted; then 9 followed by blank on digit 0.
        hold(7'b0000000, 4'b0011, 10);
        chk("multi_en_digits", 32'(digits), 32'hFF75);
        chk("multi_en_dvalid", 32'(digit_valid), 32'b0011);
        chk("multi_en_no_ev", 32'(ev_valid), 0);
        hold(7'b0000100, 4'b0001, 5);
        chk("ev_9", {28'd0, ev_value}, 9);
        pop();
        hold(7'h7F, 4'b0001, 5);
        chk("ev_blank", {27'd0, ev_valid, ev_value}, {27'd0, 1'b1, 4'hF});
        chk("blank_dvalid", 32'(digit_valid[0]), 0);
        pop();
        // Same blank re-accepted after a break: no new event.
        hold(7'h7F, 4'b0000, 1);
        hold(7'h7F, 4'b0001, 6);
        chk("reaccept_no_ev", 32'(ev_valid), 0);

        // Async reset mid-count with an event pending.
        hold(7'b0000001, 4'b0100, 5);
        chk("pre_rst_ev", 32'(ev_valid), 1);
        hold(7'b1001111, 4'b1000, 4);
        #1 rst = 1'b0;
        #1;
        chk_reset_vals();
        @(posedge clk);
        #2 rst = 1'b1;
        hold(7'b1001111, 4'b1000, 4);
        chk("post_rst_full_wait", 32'(ev_valid), 0);
        cyc();
        chk("post_rst_ev", {25'd0, ev_valid, ev_index, ev_value}, {25'd0, 1'b1, 2'd3, 4'd1});
        pop();
        hold(7'h7F, 4'b0000, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/segment_pattern_decoder.md
Name: segment_pattern_decoder

Overview:
- Receive-side counterpart of the button-driven 7-segment display driver.
- Samples a multiplexed, active-low 7-segment bus (pattern plus one-hot digit enable) and filters it for stability.
- Decodes each stable pattern back to a BCD value and keeps a per-digit shadow register.
- Reports every digit change through a single-entry valid/ready event port. Used for loopback self-test of display boards and as a front-end for display-snooping logic.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before accepting a pattern (>=2).
- IDX_W, 2, width of ev_index; must be >= max(1, clog2(NUM_DIGITS)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- segment  in  7  active-low pattern; bit6=a ... bit0=g.
- digit_en  in  NUM_DIGITS  one-hot, active-high; selects the digit currently driven.
- digits  out  4*NUM_DIGITS  packed shadow values; digit i is at [4i+3:4i].
- digit_valid  out  NUM_DIGITS  1 = digit i holds a decoded numeral 0..9.
- ev_valid  out  1  change event pending.
- ev_ready  in  1  consumer accepts the event.
- ev_index  out  IDX_W  digit index of the pending event.
- ev_value  out  4  new value of that digit (F = blank).
- ev_overrun  out  1  sticky flag: an event was dropped.
- ev_overrun_clr  in  1  synchronous clear for ev_overrun.
- pattern_err  out  1  one-cycle pulse on acceptance of an undecodable pattern.
- err_count  out  8  count of undecodable patterns, saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous): digits all 4'hF; digit_valid 0; ev_valid 0; ev_index 0; ev_value 0; ev_overrun 0; pattern_err 0; err_count 0; input register, hold register and stability counter cleared. A reset asserted mid-run discards any partial stability count and any pending event.
- Decode table (segment -> value):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4
  - 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9
  - 1111111 -> blank (value F, digit_valid 0)
  - any other pattern -> invalid
- Stage 1: {segment, digit_en} is registered every cycle into an input register s.
- Stage 2: s is compared with a hold register h.
  - If s differs from h: load h <= s and set cnt <= 1.
  - If s equals h: cnt increments, saturating at STABLE_CYCLES.
  - If s.digit_en is not exactly one-hot (zero or multiple bits): force cnt <= 0; nothing is accepted.
- Accept: fires in the cycle where s equals h, s.digit_en is one-hot and cnt == STABLE_CYCLES-1. Effects land on the same edge (cnt becomes STABLE_CYCLES).
  - There is exactly one accept per stable run; a run held longer does not re-accept.
  - Latency: input stable before edge 1 -> outputs update after edge STABLE_CYCLES+1 (5 edges at default).
- On accept for digit i:
  - Valid numeral or blank: digits[i] <= value; digit_valid[i] <= (value != F).
  - Invalid pattern: digits and digit_valid unchanged; pattern_err = 1 for one cycle; err_count += 1 unless already 255.
- Change event: raised when an accepted valid/blank value differs from the previous digits[i]. Re-accepting an identical value raises no event.
- Event port (single holding register):
  - ev_valid stays high, and ev_index/ev_value stay constant, until sampled with ev_ready=1 on a rising edge.
  - Transfer and new event on the same edge: the new event loads and ev_valid stays 1.
  - New event while ev_valid=1 and ev_ready=0: the new event is dropped and ev_overrun is set. The shadow digits are still updated. The pending event is unchanged.
  - ev_overrun clears on ev_overrun_clr=1. If a set and a clear coincide, set wins.
- Arithmetic: cnt is wide enough to hold STABLE_CYCLES. err_count never wraps.

Test Plan:
- Reset, then digit_en=0001 and segment=0010010 held for 6 cycles -> after edge 5: digits[3:0]=2, digit_valid[0]=1, ev_valid=1, ev_index=0, ev_value=2; ev_ready=1 for one cycle -> ev_valid=0.
- Glitch: segment=0000110 for 2 cycles, then 0000000 for 5 cycles, on digit 1 -> no event for 3; one event with ev_index=1, ev_value=8.
- Undecodable pattern 1010101 held 5 cycles on digit 2 -> pattern_err pulses once, err_count=1, digits[11:8] stays F, no event; repeat 300 runs -> err_count=255.
- ev_ready held 0 while digit 0 goes to 5 and then digit 1 goes to 7 -> event (0,5) held, ev_overrun=1, digits[7:4]=7; ev_overrun_clr=1 -> ev_overrun=0.
- digit_en=0011 with a stable pattern for 10 cycles -> no accept, no output change; also blank 1111111 after a 9 on digit 0 -> event value F, digit_valid[0]=0.
- Assert rst=0 asynchronously mid-count (cnt=3) and with ev_valid=1 -> all outputs return to reset values immediately; after release the same stable input needs a full 5 edges again.
